// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package i2s_pkg;

  localparam int I2S_BITS = 16;

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    RUN
  } state_t;

  localparam logic CHAN_LEFT  = 1'b0;
  localparam logic CHAN_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_sync.sv
// Multi-flop synchronizer for one async pin plus an edge flop and rising-edge pulse.
// Latency: STAGES clk to sync_q, STAGES+1 clk to edge_q.
// Backpressure: none, free-running.
module i2s_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic sync_q,
  output logic edge_q,
  output logic rise
);

  logic [STAGES-1:0] chain;

  // Shift the pin through the synchronizer chain, then one more flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain  <= '0;
      edge_q <= 1'b0;
    end else begin
      chain  <= {chain[STAGES-2:0], d};
      edge_q <= sync_q;
    end
  end

  assign sync_q = chain[STAGES-1];
  assign rise   = sync_q & ~edge_q;

endmodule

// File: rtl/i2si_deserializer.sv
// I2S receiver: samples sck/ws/sd in clk domain, deserializes MSB-first stereo pairs.
// Latency: rts rises SYNC_STAGES+1 clk after the pin sck rise carrying the right LSB.
// Backpressure: rts/rtr; a pair completing while rts=1 and rtr=0 is dropped and sets overrun.
module i2si_deserializer
  import i2s_pkg::*;
#(
  parameter int BITS        = I2S_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            sck,
  input  logic            ws,
  input  logic            sd,
  output logic [BITS-1:0] data_left,
  output logic [BITS-1:0] data_right,
  output logic            rts,
  input  logic            rtr,
  output logic            overrun,
  input  logic            overrun_clr,
  output logic            frame_err
);

  localparam int CW = $clog2(BITS + 2);
  localparam int IW = $clog2(BITS);

  logic sck_sync, sck_d, sck_rise;
  logic ws_sync, ws_cur, ws_rise;
  logic sd_sync, sd_cur, sd_rise;
  logic unused_sync;

  // All three pins go through the same depth so ws/sd stay aligned with the sck edge.
  i2s_sync #(.STAGES(SYNC_STAGES)) u_sync_sck (
    .clk(clk), .rst_n(rst_n), .d(sck), .sync_q(sck_sync), .edge_q(sck_d), .rise(sck_rise)
  );
  i2s_sync #(.STAGES(SYNC_STAGES)) u_sync_ws (
    .clk(clk), .rst_n(rst_n), .d(ws), .sync_q(ws_sync), .edge_q(ws_cur), .rise(ws_rise)
  );
  i2s_sync #(.STAGES(SYNC_STAGES)) u_sync_sd (
    .clk(clk), .rst_n(rst_n), .d(sd), .sync_q(sd_sync), .edge_q(sd_cur), .rise(sd_rise)
  );

  assign unused_sync = ^{sck_sync, sck_d, ws_sync, ws_rise, sd_sync, sd_rise};

  state_t            state_q, state_d;
  logic [CW-1:0]     bit_cnt;
  logic [IW-1:0]     bit_idx;
  logic [BITS-1:0]   sreg, hold_left, word_next;
  logic              chan, ws_prev;
  logic              align_hit, word_end, pair_done, bit_in_range;

  assign bit_in_range = (bit_cnt < CW'(BITS));
  assign bit_idx      = IW'(BITS - 1) - bit_cnt[IW-1:0];

  // Next-state and per-rise events; disabling overrides everything back to IDLE.
  always_comb begin
    state_d   = state_q;
    align_hit = 1'b0;
    word_end  = 1'b0;
    pair_done = 1'b0;
    word_next = sreg;
    if (bit_in_range) word_next[bit_idx] = sd_cur;
    case (state_q)
      IDLE:  if (en) state_d = ALIGN;
      ALIGN: begin
        if (sck_rise && ws_prev && !ws_cur) begin
          align_hit = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (sck_rise && (ws_cur != ws_prev)) begin
          word_end  = 1'b1;
          pair_done = (chan == CHAN_RIGHT);
        end
      end
      default: state_d = IDLE;
    endcase
    if (!en) begin
      state_d   = IDLE;
      align_hit = 1'b0;
      word_end  = 1'b0;
      pair_done = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ws value seen at the previous sck rise, used to find word boundaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        ws_prev <= 1'b0;
    else if (sck_rise) ws_prev <= ws_cur;
  end

  // Bit counter, shift register and held left word; each word starts from a cleared sreg.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      sreg      <= '0;
      hold_left <= '0;
      chan      <= CHAN_LEFT;
    end else if (state_q == IDLE || !en || align_hit) begin
      bit_cnt <= '0;
      sreg    <= '0;
      chan    <= CHAN_LEFT;
    end else if (state_q == RUN && sck_rise) begin
      if (word_end) begin
        bit_cnt <= '0;
        sreg    <= '0;
        chan    <= ~chan;
        if (chan == CHAN_LEFT) hold_left <= word_next;
      end else begin
        sreg <= word_next;
        if (bit_cnt != CW'(BITS + 1)) bit_cnt <= bit_cnt + CW'(1);
      end
    end
  end

  // Output pair register, handshake, sticky overrun (set beats clear) and frame error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_left  <= '0;
      data_right <= '0;
      rts        <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_err <= word_end && (bit_cnt != CW'(BITS - 1));
      if (!en || state_q == IDLE) begin
        rts <= 1'b0;
      end else if (pair_done && (!rts || rtr)) begin
        data_left  <= hold_left;
        data_right <= word_next;
        rts        <= 1'b1;
      end else if (rts && rtr) begin
        rts <= 1'b0;
      end
      if (pair_done && rts && !rtr) overrun <= 1'b1;
      else if (overrun_clr)         overrun <= 1'b0;
    end
  end

endmodule
